// File: rtl/apb_pkg.sv
// Shared APB definitions: FSM states, default bus widths
// and the strobe-width derivation used by slaves and agents.
package apb_pkg;

  localparam int APB_ADDR_W = 32;
  localparam int APB_DATA_W = 32;

  function automatic int strb_w(input int dw);
    return dw / 8;
  endfunction

  localparam int APB_STRB_W = strb_w(APB_DATA_W);

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

endpackage

// File: rtl/apb_slave_regs_if.sv
// APB bus bundle. master drives addr/ctrl/wdata/strb,
// slave returns pready/prdata/pslverr.
interface apb_slave_regs_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] paddr;
  logic [2:0]            pprot;
  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [STRB_W-1:0]     pstrb;
  logic                  pready;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pslverr;

  modport master (
    output paddr, pprot, psel, penable,
    output pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  paddr, pprot, psel, penable,
    input  pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );

endinterface

// File: rtl/apb_reg_bank.sv
// Register storage with byte-strobe write merge and read mux.
// Ports: clk/rst_n, write (we/widx/wdata/wstrb), read (ridx/rdata), regs_o.
module apb_reg_bank #(
  parameter int N_REGS     = 8,
  parameter int DATA_WIDTH = 32,
  parameter int IDX_W      = 3,
  localparam int STRB_W    = DATA_WIDTH / 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         we,
  input  logic [IDX_W-1:0]             widx,
  input  logic [DATA_WIDTH-1:0]        wdata,
  input  logic [STRB_W-1:0]            wstrb,
  input  logic [IDX_W-1:0]             ridx,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [N_REGS*DATA_WIDTH-1:0] regs_o
);

  logic [DATA_WIDTH-1:0] mem [N_REGS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_REGS; i++)
        mem[i] <= '0;
    end else if (we) begin
      for (int i = 0; i < N_REGS; i++) begin
        if (widx == IDX_W'(i)) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (wstrb[b])
              mem[i][b*8 +: 8] <= wdata[b*8 +: 8];
          end
        end
      end
    end
  end

  // Out-of-range index reads as zero.
  always_comb begin
    rdata = '0;
    for (int i = 0; i < N_REGS; i++) begin
      if (ridx == IDX_W'(i))
        rdata = mem[i];
    end
  end

  always_comb begin
    regs_o = '0;
    for (int i = 0; i < N_REGS; i++)
      regs_o[i*DATA_WIDTH +: DATA_WIDTH] = mem[i];
  end

endmodule

// File: rtl/apb_slave_regs.sv
// APB register slave: IDLE/ACCESS FSM, wait-state counter, error decode.
// Ports: pclk, presetn, bus (APB slave modport), regs_o (flat register view).
module apb_slave_regs
  import apb_pkg::*;
#(
  parameter int N_REGS      = 8,
  parameter int DATA_WIDTH  = APB_DATA_W,
  parameter int ADDR_WIDTH  = APB_ADDR_W,
  parameter int WAIT_STATES = 0
) (
  input  logic                         pclk,
  input  logic                         presetn,
  apb_slave_regs_if.slave              bus,
  output logic [N_REGS*DATA_WIDTH-1:0] regs_o
);

  localparam int STRB_W = strb_w(DATA_WIDTH);
  localparam int IDX_W  = (N_REGS > 1) ? $clog2(N_REGS) : 1;
  localparam int CNT_W  = 4;
  localparam logic [CNT_W-1:0] WS = CNT_W'(WAIT_STATES);
  localparam logic [ADDR_WIDTH-1:0] TOP = ADDR_WIDTH'(4 * N_REGS);

  apb_state_e state, nstate;

  logic [CNT_W-1:0]      cnt;
  logic                  wr_q;
  logic                  err_q;
  logic [IDX_W-1:0]      idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [STRB_W-1:0]     strb_q;
  logic [2:0]            prot_q;

  logic                  setup;
  logic                  complete;
  logic                  abort;
  logic                  tick;
  logic                  we;
  logic                  addr_err;
  logic [IDX_W-1:0]      idx;
  logic [DATA_WIDTH-1:0] rdata;

  assign idx      = bus.paddr[IDX_W+1:2];
  assign addr_err = (bus.paddr[1:0] != 2'b00)
                 || (bus.paddr >= TOP);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= ST_IDLE;
    else          state <= nstate;
  end

  always_comb begin
    nstate = state;
    unique case (state)
      ST_IDLE:   if (setup) nstate = ST_ACCESS;
      ST_ACCESS: if (complete || abort) nstate = ST_IDLE;
      default:   nstate = ST_IDLE;
    endcase
  end

  always_comb begin
    setup    = 1'b0;
    complete = 1'b0;
    abort    = 1'b0;
    tick     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        setup = bus.psel && !bus.penable;
      end
      ST_ACCESS: begin
        complete = bus.psel && bus.penable && bus.pready;
        abort    = !bus.psel;
        tick     = bus.psel && !bus.pready && (cnt != '0);
      end
      default: ;
    endcase
  end

  assign we = complete && wr_q && !err_q;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cnt         <= '0;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      idx_q       <= '0;
      wdata_q     <= '0;
      strb_q      <= '0;
      prot_q      <= '0;
      bus.pready  <= 1'b0;
      bus.pslverr <= 1'b0;
      bus.prdata  <= '0;
    end else if (setup) begin
      cnt         <= WS;
      wr_q        <= bus.pwrite;
      err_q       <= addr_err;
      idx_q       <= idx;
      wdata_q     <= bus.pwdata;
      strb_q      <= bus.pstrb;
      prot_q      <= bus.pprot;
      bus.pready  <= (WAIT_STATES == 0);
      bus.pslverr <= (WAIT_STATES == 0) && addr_err;
      // Read data is sampled now and held through the access phase.
      bus.prdata  <= (!bus.pwrite && !addr_err) ? rdata : '0;
    end else if (complete || abort) begin
      cnt         <= '0;
      bus.pready  <= 1'b0;
      bus.pslverr <= 1'b0;
      bus.prdata  <= '0;
    end else if (tick) begin
      cnt <= cnt - 1'b1;
      if (cnt == CNT_W'(1)) begin
        bus.pready  <= 1'b1;
        bus.pslverr <= err_q;
      end
    end
  end

  apb_reg_bank #(
    .N_REGS     (N_REGS),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_W      (IDX_W)
  ) u_bank (
    .clk    (pclk),
    .rst_n  (presetn),
    .we     (we),
    .widx   (idx_q),
    .wdata  (wdata_q),
    .wstrb  (strb_q),
    .ridx   (idx),
    .rdata  (rdata),
    .regs_o (regs_o)
  );

endmodule

// File: tb/tb_apb_slave_regs.sv
// Directed bench: two slaves (0 and 3 wait states) on a shared
// stimulus bus, psel steered by use3.
module tb_apb_slave_regs;

  logic pclk = 1'b0;
  always #5 pclk = ~pclk;

  logic        presetn;
  logic        use3;
  logic        psel, penable, pwrite;
  logic [31:0] paddr, pwdata;
  logic [3:0]  pstrb;

  apb_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) i0 ();
  apb_slave_regs_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) i3 ();

  assign i0.paddr   = paddr;
  assign i0.pprot   = 3'b010;
  assign i0.psel    = psel & ~use3;
  assign i0.penable = penable;
  assign i0.pwrite  = pwrite;
  assign i0.pwdata  = pwdata;
  assign i0.pstrb   = pstrb;

  assign i3.paddr   = paddr;
  assign i3.pprot   = 3'b001;
  assign i3.psel    = psel & use3;
  assign i3.penable = penable;
  assign i3.pwrite  = pwrite;
  assign i3.pwdata  = pwdata;
  assign i3.pstrb   = pstrb;

  logic [255:0] regs0, regs3;

  apb_slave_regs #(.WAIT_STATES(0)) dut0 (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (i0),
    .regs_o  (regs0)
  );

  apb_slave_regs #(.WAIT_STATES(3)) dut3 (
    .pclk    (pclk),
    .presetn (presetn),
    .bus     (i3),
    .regs_o  (regs3)
  );

  logic        pready, pslverr;
  logic [31:0] prdata;
  assign pready  = use3 ? i3.pready  : i0.pready;
  assign pslverr = use3 ? i3.pslverr : i0.pslverr;
  assign prdata  = use3 ? i3.prdata  : i0.prdata;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] rd;
  logic        err;
  int          waits;

  task automatic xfer(input logic wr, input logic [31:0] a,
                      input logic [31:0] d, input logic [3:0] s);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0;
    pwrite = wr; paddr = a; pwdata = d; pstrb = s;
    @(negedge pclk);
    penable = 1'b1;
    waits = 0;
    while (pready !== 1'b1 && waits < 40) begin
      waits++;
      @(negedge pclk);
    end
    rd  = prdata;
    err = pslverr;
    @(posedge pclk);
    #1;
  endtask

  task automatic idle();
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic test_reset();
    vectors++;
    if (i0.pready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_pready0 got %b want 0", i0.pready);
    end
    vectors++;
    if (i0.pslverr !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_pslverr0 got %b want 0", i0.pslverr);
    end
    vectors++;
    if (i0.prdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rst_prdata0 got %h want 0", i0.prdata);
    end
    vectors++;
    if (regs0 !== 256'h0) begin
      miscompares++;
      $display("FAIL rst_regs0 got %h want 0", regs0);
    end
    vectors++;
    if (i3.pready !== 1'b0 || regs3 !== 256'h0) begin
      miscompares++;
      $display("FAIL rst_dut3 got %b/%h want 0/0", i3.pready, regs3);
    end
  endtask

  task automatic test_full_write();
    use3 = 1'b0;
    xfer(1'b1, 32'h0, 32'hDEADBEEF, 4'hF);
    vectors++;
    if (waits !== 0 || err !== 1'b0 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL wr0 got w%0d e%b d%h want w0 e0 d0", waits, err, rd);
    end
    xfer(1'b1, 32'h4, 32'hCAFEBABE, 4'hF);
    vectors++;
    if (waits !== 0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL wr4 got w%0d e%b want w0 e0", waits, err);
    end
    vectors++;
    if (regs0[63:0] !== 64'hCAFEBABE_DEADBEEF) begin
      miscompares++;
      $display("FAIL regs_o01 got %h want cafebabedeadbeef", regs0[63:0]);
    end
    xfer(1'b0, 32'h0, 32'h0, 4'h0);
    vectors++;
    if (rd !== 32'hDEADBEEF || err !== 1'b0 || waits !== 0) begin
      miscompares++;
      $display("FAIL rd0 got %h e%b w%0d want deadbeef e0 w0", rd, err, waits);
    end
    xfer(1'b0, 32'h4, 32'h0, 4'h0);
    vectors++;
    if (rd !== 32'hCAFEBABE || err !== 1'b0) begin
      miscompares++;
      $display("FAIL rd4 got %h e%b want cafebabe e0", rd, err);
    end
    idle();
  endtask

  task automatic test_strobe();
    use3 = 1'b0;
    xfer(1'b1, 32'h0, 32'h11223344, 4'b0101);
    vectors++;
    if (regs0[31:0] !== 32'hDE22BE44) begin
      miscompares++;
      $display("FAIL strb_regs got %h want de22be44", regs0[31:0]);
    end
    xfer(1'b0, 32'h0, 32'hFFFFFFFF, 4'hF);
    vectors++;
    if (rd !== 32'hDE22BE44 || regs0[31:0] !== 32'hDE22BE44) begin
      miscompares++;
      $display("FAIL strb_rd got %h/%h want de22be44", rd, regs0[31:0]);
    end
    idle();
  endtask

  task automatic test_errors();
    logic [255:0] snap;
    use3 = 1'b0;
    snap = regs0;
    xfer(1'b1, 32'h20, 32'hFFFFFFFF, 4'hF);
    vectors++;
    if (err !== 1'b1 || waits !== 0 || regs0 !== snap) begin
      miscompares++;
      $display("FAIL err_wr20 got e%b w%0d r%h want e1 w0 unchanged",
               err, waits, regs0[63:0]);
    end
    xfer(1'b1, 32'h2, 32'hFFFFFFFF, 4'hF);
    vectors++;
    if (err !== 1'b1 || regs0 !== snap) begin
      miscompares++;
      $display("FAIL err_wr2 got e%b r%h want e1 unchanged", err, regs0[63:0]);
    end
    xfer(1'b0, 32'h20, 32'h0, 4'h0);
    vectors++;
    if (err !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL err_rd20 got e%b d%h want e1 d0", err, rd);
    end
    xfer(1'b0, 32'h4, 32'h0, 4'h0);
    vectors++;
    if (err !== 1'b0 || rd !== 32'hCAFEBABE) begin
      miscompares++;
      $display("FAIL err_recover got e%b d%h want e0 cafebabe", err, rd);
    end
    idle();
  endtask

  task automatic test_wait_states();
    use3 = 1'b1;
    xfer(1'b1, 32'h4, 32'hA5A50001, 4'hF);
    vectors++;
    if (waits !== 3 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL ws_wr got w%0d e%b want w3 e0", waits, err);
    end
    xfer(1'b0, 32'h4, 32'h0, 4'h0);
    vectors++;
    if (waits !== 3 || rd !== 32'hA5A50001 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL ws_rd got w%0d d%h e%b want w3 a5a50001 e0",
               waits, rd, err);
    end
    xfer(1'b1, 32'h8, 32'h12345678, 4'hF);
    vectors++;
    if (waits !== 3 || regs3[95:64] !== 32'h12345678) begin
      miscompares++;
      $display("FAIL ws_b2b got w%0d r%h want w3 12345678",
               waits, regs3[95:64]);
    end
    xfer(1'b0, 32'h22, 32'h0, 4'h0);
    vectors++;
    if (waits !== 3 || err !== 1'b1 || rd !== 32'h0) begin
      miscompares++;
      $display("FAIL ws_err got w%0d e%b d%h want w3 e1 d0", waits, err, rd);
    end
    idle();
  endtask

  task automatic test_abort();
    use3 = 1'b1;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 32'hC; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    @(negedge pclk);
    vectors++;
    if (i3.pready !== 1'b0 || regs3[127:96] !== 32'h0) begin
      miscompares++;
      $display("FAIL abort got p%b r%h want p0 r0", i3.pready, regs3[127:96]);
    end
    xfer(1'b0, 32'hC, 32'h0, 4'h0);
    vectors++;
    if (waits !== 3 || rd !== 32'h0 || err !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_next got w%0d d%h e%b want w3 d0 e0",
               waits, rd, err);
    end
    idle();
  endtask

  task automatic test_reset_mid();
    use3 = 1'b1;
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0;
    pwrite = 1'b1; paddr = 32'h8; pwdata = 32'hFFFFFFFF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1;
    @(negedge pclk);
    presetn = 1'b0;
    #1;
    vectors++;
    if (i3.pready !== 1'b0 || i3.pslverr !== 1'b0 || i3.prdata !== 32'h0) begin
      miscompares++;
      $display("FAIL rstmid_out got p%b e%b d%h want 0",
               i3.pready, i3.pslverr, i3.prdata);
    end
    vectors++;
    if (regs3 !== 256'h0 || regs0 !== 256'h0) begin
      miscompares++;
      $display("FAIL rstmid_regs got %h/%h want 0", regs3[127:0], regs0[127:0]);
    end
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    presetn = 1'b1;
    xfer(1'b0, 32'h8, 32'h0, 4'h0);
    vectors++;
    if (rd !== 32'h0 || waits !== 3) begin
      miscompares++;
      $display("FAIL rstmid_rd got d%h w%0d want d0 w3", rd, waits);
    end
    xfer(1'b1, 32'h8, 32'h0BADF00D, 4'hF);
    xfer(1'b0, 32'h8, 32'h0, 4'h0);
    vectors++;
    if (rd !== 32'h0BADF00D || regs3[95:64] !== 32'h0BADF00D) begin
      miscompares++;
      $display("FAIL rstmid_after got %h/%h want 0badf00d", rd, regs3[95:64]);
    end
    idle();
  endtask

  initial begin
    presetn = 1'b0;
    use3 = 1'b0;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    repeat (3) @(negedge pclk);
    test_reset();
    @(negedge pclk);
    presetn = 1'b1;
    test_full_write();
    test_strobe();
    test_errors();
    test_wait_states();
    test_abort();
    test_reset_mid();
    repeat (2) @(negedge pclk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
